// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared ExcCodes, status bit indices and FSM states for the exception request controller
package exc_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam int ST_IE    = 0;
    localparam int ST_SYS   = 1;
    localparam int ST_BP    = 2;
    localparam int ST_TR    = 3;
    localparam int ST_IM_LO = 8;

    typedef enum logic [2:0] {
        IDLE,
        EXC,
        ERET,
        DROP,
        REDIR
    } exc_state_e;

    function automatic logic [4:0] trap_code(input logic [1:0] idx);
        case (idx)
            2'd0:    trap_code = EXC_SYS;
            2'd1:    trap_code = EXC_BP;
            default: trap_code = EXC_TR;
        endcase
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-line 2-flop synchronizer, rising-edge detect and sticky pending flag
module irq_sync_edge #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] clr_i,
    output logic [NUM_IRQ-1:0] pending_o
);

    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] rise;

    // A fresh edge beats a same-cycle clear so that it is never lost.
    assign rise      = sync2_q & ~prev_q;
    assign pending_d = (pending_q & ~clr_i) | rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= irq_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/exc_req_ctrl.sv
// rtl/exc_req_ctrl.sv - arbitrates trap/eret/irq requests and sequences CP0 writes and the PC redirect
module exc_req_ctrl
    import exc_pkg::*;
#(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         trap_req_i,
    input  logic               eret_req_i,
    input  logic [31:0]        pc_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [31:0]        status_i,
    input  logic [31:0]        epc_i,
    output logic               cp0_we_o,
    output logic               cp0_exception_o,
    output logic               cp0_eret_o,
    output logic [4:0]         cp0_cause_o,
    output logic [31:0]        cp0_pc_o,
    output logic               req_ack_o,
    output logic               stall_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    exc_state_e         state_q;
    logic               cp0_we_q;
    logic               cp0_exception_q;
    logic               cp0_eret_q;
    logic [4:0]         cp0_cause_q;
    logic [31:0]        cp0_pc_q;
    logic               req_ack_q;
    logic               stall_q;
    logic               redirect_q;
    logic               from_eret_q;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_enabled;
    logic [NUM_IRQ-1:0] irq_lowest;
    logic [NUM_IRQ-1:0] irq_clr;
    logic               trap_any;
    logic               trap_en;
    logic [1:0]         trap_idx;
    logic               irq_any;
    logic               unused_status;

    assign unused_status = ^{status_i[31:ST_IM_LO+NUM_IRQ], status_i[ST_IM_LO-1:ST_TR+1]};

    irq_sync_edge #(
        .NUM_IRQ(NUM_IRQ)
    ) u_irq_sync_edge (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .irq_i    (irq_i),
        .clr_i    (irq_clr),
        .pending_o(pending)
    );

    // Illegal multi-hot traps resolve to the lowest set bit.
    always_comb begin
        trap_any = |trap_req_i;
        trap_idx = 2'd0;
        if (trap_req_i[0])      trap_idx = 2'd0;
        else if (trap_req_i[1]) trap_idx = 2'd1;
        else if (trap_req_i[2]) trap_idx = 2'd2;
        case (trap_idx)
            2'd0:    trap_en = status_i[ST_IE] & status_i[ST_SYS];
            2'd1:    trap_en = status_i[ST_IE] & status_i[ST_BP];
            default: trap_en = status_i[ST_IE] & status_i[ST_TR];
        endcase
        irq_enabled = pending & status_i[ST_IM_LO +: NUM_IRQ] & {NUM_IRQ{status_i[ST_IE]}};
        irq_lowest  = irq_enabled & (~irq_enabled + NUM_IRQ'(1));
        irq_any     = |irq_enabled;
        irq_clr     = '0;
        if (state_q == IDLE && !trap_any && !eret_req_i) irq_clr = irq_lowest;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cp0_we_q        <= 1'b0;
            cp0_exception_q <= 1'b0;
            cp0_eret_q      <= 1'b0;
            cp0_cause_q     <= '0;
            cp0_pc_q        <= '0;
            req_ack_q       <= 1'b0;
            stall_q         <= 1'b0;
            redirect_q      <= 1'b0;
            from_eret_q     <= 1'b0;
        end else begin
            cp0_we_q        <= 1'b0;
            cp0_exception_q <= 1'b0;
            cp0_eret_q      <= 1'b0;
            cp0_cause_q     <= '0;
            cp0_pc_q        <= '0;
            req_ack_q       <= 1'b0;
            stall_q         <= 1'b0;
            redirect_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_any) begin
                        stall_q   <= 1'b1;
                        req_ack_q <= 1'b1;
                        if (trap_en) begin
                            state_q         <= EXC;
                            cp0_we_q        <= 1'b1;
                            cp0_exception_q <= 1'b1;
                            cp0_cause_q     <= trap_code(trap_idx);
                            cp0_pc_q        <= pc_i;
                            from_eret_q     <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (eret_req_i) begin
                        state_q         <= ERET;
                        cp0_we_q        <= 1'b1;
                        cp0_exception_q <= 1'b1;
                        cp0_eret_q      <= 1'b1;
                        req_ack_q       <= 1'b1;
                        stall_q         <= 1'b1;
                        from_eret_q     <= 1'b1;
                    end else if (irq_any) begin
                        state_q         <= EXC;
                        cp0_we_q        <= 1'b1;
                        cp0_exception_q <= 1'b1;
                        cp0_cause_q     <= EXC_INT;
                        cp0_pc_q        <= pc_i;
                        stall_q         <= 1'b1;
                        from_eret_q     <= 1'b0;
                    end
                end
                EXC, ERET: begin
                    state_q    <= REDIR;
                    stall_q    <= 1'b1;
                    redirect_q <= 1'b1;
                end
                DROP:    state_q <= IDLE;
                REDIR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cp0_we_o        = cp0_we_q;
    assign cp0_exception_o = cp0_exception_q;
    assign cp0_eret_o      = cp0_eret_q;
    assign cp0_cause_o     = cp0_cause_q;
    assign cp0_pc_o        = cp0_pc_q;
    assign req_ack_o       = req_ack_q;
    assign redirect_o      = redirect_q;
    // EPC is read live in the redirect cycle so a late CP0 update is honoured.
    assign redirect_pc_o   = !redirect_q ? 32'd0 : (from_eret_q ? epc_i : EXC_VECTOR);
    assign stall_o         = stall_q |
                             (!rst_i && state_q == IDLE && ((|trap_req_i) || eret_req_i));
    assign irq_pending_o   = pending;

endmodule

// File: tb/tb_exc_req_ctrl.sv
// tb/tb_exc_req_ctrl.sv - table-driven and sequence checks for exc_req_ctrl
module tb_exc_req_ctrl;

    localparam int          NIRQ = 8;
    localparam logic [31:0] VEC  = 32'h00400004;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      trap_req;
    logic            eret_req;
    logic [31:0]     pc;
    logic [NIRQ-1:0] irq;
    logic [31:0]     status;
    logic [31:0]     epc;
    logic            cp0_we, cp0_exception, cp0_eret, req_ack, stall, redirect;
    logic [4:0]      cp0_cause;
    logic [31:0]     cp0_pc, redirect_pc;
    logic [NIRQ-1:0] irq_pending;

    int tests  = 0;
    int failed = 0;

    exc_req_ctrl #(
        .NUM_IRQ   (NIRQ),
        .EXC_VECTOR(VEC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .trap_req_i     (trap_req),
        .eret_req_i     (eret_req),
        .pc_i           (pc),
        .irq_i          (irq),
        .status_i       (status),
        .epc_i          (epc),
        .cp0_we_o       (cp0_we),
        .cp0_exception_o(cp0_exception),
        .cp0_eret_o     (cp0_eret),
        .cp0_cause_o    (cp0_cause),
        .cp0_pc_o       (cp0_pc),
        .req_ack_o      (req_ack),
        .stall_o        (stall),
        .redirect_o     (redirect),
        .redirect_pc_o  (redirect_pc),
        .irq_pending_o  (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  trap;
        logic        eret;
        logic [31:0] status;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        exp_we;
        logic        exp_eret;
        logic [4:0]  exp_cause;
        logic [31:0] exp_cp0pc;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_strobes(input string tag);
        check({tag, " cp0_we"},   {31'd0, cp0_we},   32'd0);
        check({tag, " redirect"}, {31'd0, redirect}, 32'd0);
        check({tag, " stall"},    {31'd0, stall},    32'd0);
    endtask

    initial begin
        vecs[0] = '{"syscall",     3'b001, 1'b0, 32'h3, 32'h00400100, 32'h0, 1'b1, 1'b0, 5'd8,  32'h00400100, 1'b1, VEC};
        vecs[1] = '{"masked_bp",   3'b010, 1'b0, 32'h1, 32'h00400110, 32'h0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[2] = '{"eret",        3'b000, 1'b1, 32'h0, 32'h00400300, 32'h00400200, 1'b1, 1'b1, 5'd0, 32'h0, 1'b1, 32'h00400200};
        vecs[3] = '{"break",       3'b010, 1'b0, 32'h5, 32'h00400120, 32'h0, 1'b1, 1'b0, 5'd9,  32'h00400120, 1'b1, VEC};
        vecs[4] = '{"teq",         3'b100, 1'b0, 32'h9, 32'h00400130, 32'h0, 1'b1, 1'b0, 5'd13, 32'h00400130, 1'b1, VEC};
        vecs[5] = '{"teq_ie_off",  3'b100, 1'b0, 32'h8, 32'h00400140, 32'h0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[6] = '{"sys_ie_off",  3'b001, 1'b0, 32'h2, 32'h00400150, 32'h0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[7] = '{"multi_sysbp", 3'b011, 1'b0, 32'h7, 32'h00400160, 32'h0, 1'b1, 1'b0, 5'd8,  32'h00400160, 1'b1, VEC};
        vecs[8] = '{"multi_bptr",  3'b110, 1'b0, 32'h5, 32'h00400170, 32'h0, 1'b1, 1'b0, 5'd9,  32'h00400170, 1'b1, VEC};

        rst = 1'b1; trap_req = '0; eret_req = 1'b0; pc = '0; irq = '0; status = '0; epc = '0;
        step(); step();
        check("reset cp0_we",      {31'd0, cp0_we},        32'd0);
        check("reset cp0_exc",     {31'd0, cp0_exception}, 32'd0);
        check("reset req_ack",     {31'd0, req_ack},       32'd0);
        check("reset redirect_pc", redirect_pc,            32'd0);
        check("reset irq_pending", {24'd0, irq_pending},   32'd0);
        check_idle_strobes("reset");
        rst = 1'b0;
        step();

        foreach (vecs[k]) begin
            trap_req = vecs[k].trap; eret_req = vecs[k].eret;
            status = vecs[k].status; pc = vecs[k].pc; epc = vecs[k].epc;
            #1;
            check({vecs[k].name, " comb stall"}, {31'd0, stall}, 32'd1);
            step();
            check({vecs[k].name, " cp0_we"},    {31'd0, cp0_we},        {31'd0, vecs[k].exp_we});
            check({vecs[k].name, " cp0_exc"},   {31'd0, cp0_exception}, {31'd0, vecs[k].exp_we});
            check({vecs[k].name, " cp0_eret"},  {31'd0, cp0_eret},      {31'd0, vecs[k].exp_eret});
            check({vecs[k].name, " cause"},     {27'd0, cp0_cause},     {27'd0, vecs[k].exp_cause});
            check({vecs[k].name, " cp0_pc"},    cp0_pc,                 vecs[k].exp_cp0pc);
            check({vecs[k].name, " req_ack"},   {31'd0, req_ack},       32'd1);
            check({vecs[k].name, " stall1"},    {31'd0, stall},         32'd1);
            trap_req = '0; eret_req = 1'b0;
            step();
            check({vecs[k].name, " redirect"},  {31'd0, redirect},      {31'd0, vecs[k].exp_redir});
            check({vecs[k].name, " redir_pc"},  redirect_pc,            vecs[k].exp_rpc);
            check({vecs[k].name, " stall2"},    {31'd0, stall},         {31'd0, vecs[k].exp_redir});
            check({vecs[k].name, " ack2"},      {31'd0, req_ack},       32'd0);
            check({vecs[k].name, " we2"},       {31'd0, cp0_we},        32'd0);
            step();
            check_idle_strobes({vecs[k].name, " idle"});
        end

        // Two irq lines rise together: line 0 first, then line 1, no re-fire on held level.
        status = 32'h301; pc = 32'h00400800;
        irq = 8'h03;
        step(); step(); step();
        check("irq pend latched", {24'd0, irq_pending}, 32'h03);
        check("irq pend idle we", {31'd0, cp0_we},      32'd0);
        step();
        check("irq0 we",    {31'd0, cp0_we},      32'd1);
        check("irq0 cause", {27'd0, cp0_cause},   32'd0);
        check("irq0 pc",    cp0_pc,               32'h00400800);
        check("irq0 ack",   {31'd0, req_ack},     32'd0);
        check("irq0 pend",  {24'd0, irq_pending}, 32'h02);
        step();
        check("irq0 redir",    {31'd0, redirect}, 32'd1);
        check("irq0 redir_pc", redirect_pc,       VEC);
        step();
        check("irq0 back idle", {31'd0, cp0_we}, 32'd0);
        step();
        check("irq1 we",   {31'd0, cp0_we},      32'd1);
        check("irq1 pend", {24'd0, irq_pending}, 32'h00);
        step(); step();
        for (int c = 0; c < 5; c++) begin
            step();
            check("irq held no refire", {31'd0, cp0_we}, 32'd0);
        end
        check("irq held pend", {24'd0, irq_pending}, 32'h00);

        // teq plus held eret, with an irq edge landing during EXC.
        irq = 8'h00; status = 32'h109;
        step(); step(); step(); step();
        trap_req = 3'b100; eret_req = 1'b1; pc = 32'h00400500; epc = 32'h00400600;
        step();
        check("mix teq cause", {27'd0, cp0_cause}, 32'd13);
        check("mix teq eret",  {31'd0, cp0_eret},  32'd0);
        check("mix teq ack",   {31'd0, req_ack},   32'd1);
        trap_req = '0; irq = 8'h01;
        step();
        check("mix teq redir_pc", redirect_pc, VEC);
        step();
        step();
        check("mix eret strobe", {31'd0, cp0_eret},    32'd1);
        check("mix eret ack",    {31'd0, req_ack},     32'd1);
        check("mix irq pend",    {24'd0, irq_pending}, 32'h01);
        eret_req = 1'b0;
        step();
        check("mix eret redir_pc", redirect_pc, 32'h00400600);
        step();
        step();
        check("mix irq we",    {31'd0, cp0_we},      32'd1);
        check("mix irq cause", {27'd0, cp0_cause},   32'd0);
        check("mix irq pend0", {24'd0, irq_pending}, 32'h00);
        step(); step();

        // Reset while in REDIR, with a masked irq left pending.
        status = 32'h3; irq = 8'h04;
        step(); step(); step();
        check("rst pre pend", {24'd0, irq_pending}, 32'h04);
        trap_req = 3'b001; pc = 32'h00400900;
        step();
        trap_req = '0;
        step();
        check("rst pre redir", {31'd0, redirect}, 32'd1);
        rst = 1'b1; irq = 8'h00;
        step();
        check("rst redirect", {31'd0, redirect},    32'd0);
        check("rst stall",    {31'd0, stall},       32'd0);
        check("rst pend",     {24'd0, irq_pending}, 32'h00);
        rst = 1'b0;
        step();
        check_idle_strobes("rst after");
        step();
        check_idle_strobes("rst after2");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
